nios_multi_timer: RTL and testbench

//  Avalon-MM slave holding NUM_CH independent down-counting interval timers, each with its own prescaler.

---
 rtl/nios_multi_timer_if.sv | 23 ++
 rtl/nios_multi_timer.sv | 121 ++++++++++++
 tb/tb_nios_multi_timer.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_multi_timer_if.sv
// Avalon-MM slave bus for the multi-channel interval timer.
// Transfer rule: a write is taken on every clk edge that sees chipselect=1 and write_n=0
// (no waitrequest, never back-pressured); readdata is the registered mux of address, valid one clk later.
interface nios_multi_timer_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              chipselect;
  logic [ADDR_W-1:0] address;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (
    output chipselect, address, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  chipselect, address, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_multi_timer.sv
// NUM_CH independent down-counting interval timers with per-channel prescaler,
// set-dominant timeout flag and one irq line per channel.
module nios_multi_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter int          DATA_W       = 32,
  parameter int          ADDR_W       = 4,
  parameter logic [31:0] RESET_PERIOD = 32'h1869F
) (
  input  logic                clk,
  input  logic                reset_n,
  nios_multi_timer_if.slave   bus,
  output logic [NUM_CH-1:0]   irq,
  output logic                irq_any
);

  localparam logic [CNT_W-1:0] RST_CNT = RESET_PERIOD[CNT_W-1:0];

  logic              wr_en;
  logic [ADDR_W-1:0] ch_full;
  logic [1:0]        reg_sel;
  logic              ch_valid;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign ch_full  = bus.address >> 2;
  assign reg_sel  = bus.address[1:0];
  assign ch_valid = int'(ch_full) < NUM_CH;

  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] period [NUM_CH];
  logic [CNT_W-1:0] snap   [NUM_CH];
  logic [7:0]       pcnt   [NUM_CH];
  logic [7:0]       presc  [NUM_CH];
  logic             ito    [NUM_CH];
  logic             cont   [NUM_CH];
  logic             run    [NUM_CH];
  logic             to_flag[NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel, wr_status, wr_ctrl, wr_period, wr_snap, tick, term;

    assign sel       = wr_en && ch_valid && (int'(ch_full) == i);
    assign wr_status = sel && (reg_sel == 2'd0);
    assign wr_ctrl   = sel && (reg_sel == 2'd1);
    assign wr_period = sel && (reg_sel == 2'd2);
    assign wr_snap   = sel && (reg_sel == 2'd3);
    assign tick      = run[i] && (pcnt[i] == presc[i]);
    assign term      = tick && (cnt[i] == '0);
    assign irq[i]    = to_flag[i] & ito[i];

    // Later statements override earlier ones: register writes win over the
    // free-running count, except that a timeout always survives a STATUS clear.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt[i]     <= RST_CNT;
        period[i]  <= RST_CNT;
        snap[i]    <= '0;
        pcnt[i]    <= '0;
        presc[i]   <= '0;
        ito[i]     <= 1'b0;
        cont[i]    <= 1'b0;
        run[i]     <= 1'b0;
        to_flag[i] <= 1'b0;
      end else begin
        if (run[i]) pcnt[i] <= tick ? 8'd0 : pcnt[i] + 8'd1;
        if (tick) begin
          if (term) begin
            cnt[i]     <= period[i];
            to_flag[i] <= 1'b1;
            if (!cont[i]) run[i] <= 1'b0;
          end else begin
            cnt[i] <= cnt[i] - CNT_W'(1);
          end
        end
        if (wr_status && !term) to_flag[i] <= 1'b0;
        if (wr_ctrl) begin
          ito[i]   <= bus.writedata[0];
          cont[i]  <= bus.writedata[1];
          presc[i] <= bus.writedata[15:8];
          if (bus.writedata[2]) begin
            run[i]  <= 1'b1;
            pcnt[i] <= '0;
          end else if (bus.writedata[3]) begin
            run[i] <= 1'b0;
          end
        end
        if (wr_period) begin
          period[i] <= bus.writedata[CNT_W-1:0];
          cnt[i]    <= bus.writedata[CNT_W-1:0];
          pcnt[i]   <= '0;
          run[i]    <= 1'b0;
        end
        if (wr_snap) snap[i] <= cnt[i];
      end
    end
  end

  assign irq_any = |irq;

  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(ch_full) == i) begin
        case (reg_sel)
          2'd0:    rd_mux = DATA_W'({run[i], to_flag[i]});
          2'd1:    rd_mux = DATA_W'({presc[i], 6'b0, cont[i], ito[i]});
          2'd2:    rd_mux = DATA_W'(period[i]);
          default: rd_mux = DATA_W'(snap[i]);
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.readdata <= '0;
    else          bus.readdata <= rd_mux;
  end

endmodule

// File: tb/tb_nios_multi_timer.sv
// Bench for nios_multi_timer: directed scenarios plus randomized period/prescaler runs
// checked against closed-form timing arithmetic.
module tb_nios_multi_timer;
  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int          DATA_W = 32;
  localparam int          ADDR_W = 4;
  localparam logic [31:0] RST_P  = 32'h1869F;
  localparam logic [1:0]  R_STATUS = 2'd0, R_CTRL = 2'd1, R_PERIOD = 2'd2, R_SNAP = 2'd3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
  int                cyc = 0;
  int                n_tests = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] exp_q[$];

  nios_multi_timer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  nios_multi_timer #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_PERIOD(RST_P)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave), .irq(irq), .irq_any(irq_any)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // driver tasks: called at a falling edge, each bus access consumes exactly one rising edge
  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = '0;
    bus.writedata  = '0;
  endtask

  function automatic logic [ADDR_W-1:0] adr(input int ch, input logic [1:0] r);
    return ADDR_W'(ch * 4 + int'(r));
  endfunction

  task automatic wr(input int ch, input logic [1:0] r, input logic [DATA_W-1:0] d, output int e);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = adr(ch, r);
    bus.writedata  = d;
    @(posedge clk); #1; e = cyc;
    @(negedge clk); bus_idle();
  endtask

  task automatic rd(input int ch, input logic [1:0] r, output logic [DATA_W-1:0] d);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    bus.address    = adr(ch, r);
    @(posedge clk);
    @(negedge clk); d = bus.readdata; bus_idle();
  endtask

  task automatic wait_until(input int target);
    if (target > cyc) repeat (target - cyc) @(negedge clk);
  endtask

  // reference: counter value after t prescaler ticks of a continuous channel started at p
  function automatic logic [DATA_W-1:0] cont_cnt(input int p, input int t);
    return DATA_W'(p - (t % (p + 1)));
  endfunction

  task automatic test_reset();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_r[4];
    exp_r[0] = '0; exp_r[1] = '0; exp_r[2] = RST_P; exp_r[3] = '0;
    bus_idle();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.readdata !== '0 || irq !== '0 || irq_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: readdata=%h irq=%b irq_any=%b, want 0", bus.readdata, irq, irq_any);
    end
    reset_n = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      rd(0, 2'(r), d);
      n_tests++;
      if (d !== exp_r[r]) begin
        n_fail++;
        $display("FAIL reset_ch0_reg%0d: got %h want %h", r, d, exp_r[r]);
      end
    end
    for (int c = 1; c < NUM_CH; c++) begin
      rd(c, R_PERIOD, d);
      n_tests++;
      if (d !== RST_P) begin
        n_fail++;
        $display("FAIL reset_period_ch%0d: got %h want %h", c, d, RST_P);
      end
    end
  endtask

  task automatic test_periodic();
    logic [DATA_W-1:0] d;
    int e, e0, ew;
    wr(1, R_PERIOD, 32'd9, e);
    wr(1, R_CTRL, 32'h7, e0);
    wait_until(e0 + 9);
    n_tests++;
    if (irq[1] !== 1'b0) begin n_fail++; $display("FAIL periodic_before_first: irq1=%b want 0", irq[1]); end
    wait_until(e0 + 10);
    n_tests++;
    if (irq[1] !== 1'b1 || irq_any !== 1'b1) begin
      n_fail++; $display("FAIL periodic_first: irq1=%b irq_any=%b want 1 1", irq[1], irq_any);
    end
    wait_until(e0 + 18);
    wr(1, R_STATUS, 32'd0, ew);
    n_tests++;
    if (irq[1] !== 1'b0 || ew != e0 + 19) begin
      n_fail++; $display("FAIL periodic_clear: irq1=%b edge=%0d want 0 at %0d", irq[1], ew, e0 + 19);
    end
    wait_until(e0 + 20);
    n_tests++;
    if (irq[1] !== 1'b1) begin n_fail++; $display("FAIL periodic_second: irq1=%b want 1", irq[1]); end
    wr(1, R_CTRL, 32'h8, e);
    wr(1, R_STATUS, 32'd0, e);
    rd(1, R_STATUS, d);
    n_tests++;
    if (d !== '0 || irq !== '0) begin
      n_fail++; $display("FAIL periodic_stopped: status=%h irq=%b want 0 0", d, irq);
    end
  endtask

  task automatic test_oneshot();
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] exp_s[3];
    int e, e0;
    exp_s[0] = 32'd2; exp_s[1] = 32'd2; exp_s[2] = 32'd1;
    wr(2, R_PERIOD, 32'd3, e);
    wr(2, R_CTRL, 32'h0404, e0);
    wait_until(e0 + 18);
    for (int k = 0; k < 3; k++) begin
      rd(2, R_STATUS, d);
      n_tests++;
      if (d !== exp_s[k]) begin
        n_fail++; $display("FAIL oneshot_status_%0d: got %h want %h", k, d, exp_s[k]);
      end
    end
    wr(2, R_SNAP, 32'd0, e);
    rd(2, R_SNAP, d);
    n_tests++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL oneshot_reload: got %h want 3", d); end
    wr(2, R_STATUS, 32'd0, e);
    repeat (100) @(negedge clk);
    rd(2, R_STATUS, d);
    n_tests++;
    if (d !== '0 || irq[2] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_no_retrigger: status=%h irq2=%b want 0 0", d, irq[2]);
    end
  endtask

  task automatic test_set_wins();
    logic [DATA_W-1:0] d;
    int e;
    wr(3, R_PERIOD, 32'd0, e);
    wr(3, R_CTRL, 32'h7, e);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    wr(3, R_STATUS, 32'd0, e);
    n_tests++;
    if (irq[3] !== 1'b1) begin n_fail++; $display("FAIL set_wins_irq: irq3=%b want 1", irq[3]); end
    rd(3, R_STATUS, d);
    n_tests++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL set_wins_status: got %h want 3", d); end
    wr(3, R_CTRL, 32'h8, e);
    wr(3, R_STATUS, 32'd0, e);
    rd(3, R_STATUS, d);
    n_tests++;
    if (d !== '0) begin n_fail++; $display("FAIL set_wins_cleanup: got %h want 0", d); end
  endtask

  task automatic test_snap_period();
    logic [DATA_W-1:0] d, exp_v;
    int e, e0, s, presc;
    presc = $urandom_range(0, 3);
    wr(0, R_PERIOD, 32'd50, e);
    wr(0, R_CTRL, DATA_W'(presc * 256 + 6), e0);
    repeat ($urandom_range(3, 40)) @(negedge clk);
    wr(0, R_SNAP, 32'd0, s);
    exp_v = cont_cnt(50, (s - 1 - e0) / (presc + 1));
    rd(0, R_SNAP, d);
    n_tests++;
    if (d !== exp_v) begin n_fail++; $display("FAIL snap_live: got %0d want %0d (presc %0d)", d, exp_v, presc); end
    wr(0, R_PERIOD, 32'd77, e);
    rd(0, R_STATUS, d);
    n_tests++;
    if (d !== '0) begin n_fail++; $display("FAIL period_write_stops: status=%h want 0", d); end
    repeat (7) @(negedge clk);
    wr(0, R_SNAP, 32'd0, e);
    rd(0, R_SNAP, d);
    n_tests++;
    if (d !== 32'd77) begin n_fail++; $display("FAIL period_reload: got %0d want 77", d); end
  endtask

  task automatic test_start_stop();
    logic [DATA_W-1:0] d;
    int e;
    wr(1, R_CTRL, 32'h0A0F, e);
    rd(1, R_CTRL, d);
    n_tests++;
    if (d !== 32'h0A03) begin n_fail++; $display("FAIL ctrl_readback: got %h want 00000a03", d); end
    rd(1, R_STATUS, d);
    n_tests++;
    if (d[1] !== 1'b1) begin n_fail++; $display("FAIL start_stop_run: run=%b want 1", d[1]); end
    wr(1, R_CTRL, 32'h8, e);
    wr(1, R_STATUS, 32'd0, e);
    rd(1, R_STATUS, d);
    n_tests++;
    if (d !== '0) begin n_fail++; $display("FAIL start_stop_cleanup: got %h want 0", d); end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] d, exp_v;
    int e, e0, s, t1, ch, p, presc;
    for (int it = 0; it < 8; it++) begin
      ch    = $urandom_range(0, NUM_CH - 1);
      p     = $urandom_range(0, 12);
      presc = $urandom_range(0, 3);
      wr(ch, R_PERIOD, DATA_W'(p), e);
      wr(ch, R_STATUS, 32'd0, e);
      wr(ch, R_CTRL, DATA_W'(presc * 256 + 7), e0);
      t1 = e0 + (p + 1) * (presc + 1);
      wait_until(t1 - 1);
      n_tests++;
      if (irq[ch] !== 1'b0) begin
        n_fail++; $display("FAIL rand_%0d_early: ch%0d irq=%b want 0 (p=%0d presc=%0d)", it, ch, irq[ch], p, presc);
      end
      wait_until(t1);
      n_tests++;
      if (irq[ch] !== 1'b1) begin
        n_fail++; $display("FAIL rand_%0d_timeout: ch%0d irq=%b want 1 (p=%0d presc=%0d)", it, ch, irq[ch], p, presc);
      end
      repeat ($urandom_range(0, 20)) @(negedge clk);
      wr(ch, R_SNAP, 32'd0, s);
      exp_q.push_back(cont_cnt(p, (s - 1 - e0) / (presc + 1)));
      rd(ch, R_SNAP, d);
      exp_v = exp_q.pop_front();
      n_tests++;
      if (d !== exp_v) begin
        n_fail++; $display("FAIL rand_%0d_snap: ch%0d got %0d want %0d (p=%0d presc=%0d)", it, ch, d, exp_v, p, presc);
      end
      wr(ch, R_CTRL, 32'h8, e);
      wr(ch, R_STATUS, 32'd0, e);
    end
  endtask

  task automatic test_async_reset();
    logic [DATA_W-1:0] d;
    int e;
    wr(0, R_PERIOD, 32'd2, e);
    wr(0, R_CTRL, 32'h7, e);
    wr(1, R_CTRL, 32'h7, e);
    repeat (4) @(negedge clk);
    n_tests++;
    if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: irq0=%b want 1", irq[0]); end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (irq !== '0 || irq_any !== 1'b0 || bus.readdata !== '0) begin
      n_fail++; $display("FAIL async_reset: irq=%b irq_any=%b readdata=%h want 0", irq, irq_any, bus.readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      wr(c, R_SNAP, 32'd0, e);
      rd(c, R_SNAP, d);
      n_tests++;
      if (d !== RST_P) begin n_fail++; $display("FAIL post_reset_cnt_ch%0d: got %h want %h", c, d, RST_P); end
    end
    rd(0, R_STATUS, d);
    n_tests++;
    if (d !== '0 || irq !== '0) begin
      n_fail++; $display("FAIL post_reset_status: status=%h irq=%b want 0", d, irq);
    end
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_oneshot();
    test_set_wins();
    test_snap_period();
    test_start_stop();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
